dmem_arbiter: RTL

//  Shares the single data-memory port between the CPU memory stage and the VGA scanout reader.

---
 rtl/dmem_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU memory stage and the VGA scanout reader.
// Define DMEM_ARB_PERF_EN to add the perf_cpu_stall_o / perf_vga_wait_o cycle counters.
module dmem_arbiter #(
  parameter int max_cpu_run_p  = 4,
  parameter int vga_wait_max_p = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_r_v_i,
  input  logic        cpu_w_v_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        cpu_done_o,
  output logic        cpu_stall_o,
  input  logic        vga_r_v_i,
  input  logic [31:0] vga_addr_i,
  output logic [31:0] vga_data_o,
  output logic        vga_done_o,
  output logic        mem_r_v_o,
  output logic        mem_w_v_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ready_i
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_cpu_stall_o,
  output logic [31:0] perf_vga_wait_o
`endif
);
  localparam int rw = $clog2(max_cpu_run_p + 1);
  localparam int ww = $clog2(vga_wait_max_p + 1);
  localparam logic [rw-1:0] run_max = rw'(max_cpu_run_p);
  localparam logic [ww-1:0] wait_max = ww'(vga_wait_max_p);
  typedef enum logic [1:0] {IDLE, CPU_BUSY, VGA_BUSY} state_t;
  state_t r_state, w_next;
  logic [rw-1:0] r_run;
  logic [ww-1:0] r_wait;
  logic r_mem_r, r_mem_w;
  logic [31:0] r_mem_addr, r_mem_data;
  logic w_cpu_req, w_idle, w_vga_grant, w_cpu_grant, w_fin, w_vga_waiting;
  assign w_cpu_req = cpu_r_v_i | cpu_w_v_i;
  assign w_idle = r_state == IDLE;
  assign w_vga_waiting = vga_r_v_i & (r_state != VGA_BUSY);
  assign w_vga_grant = w_idle & vga_r_v_i & (r_wait >= wait_max | r_run >= run_max | ~w_cpu_req);
  assign w_cpu_grant = w_idle & ~w_vga_grant & w_cpu_req;
  assign w_fin = ~w_idle & mem_ready_i;
  assign mem_r_v_o = r_mem_r;
  assign mem_w_v_o = r_mem_w;
  assign mem_addr_o = r_mem_addr;
  assign mem_data_o = r_mem_data;

  always_ff @(posedge clk_i) r_state <= rst_i ? IDLE : w_next;

  always_comb w_next = w_vga_grant ? VGA_BUSY : w_cpu_grant ? CPU_BUSY : w_fin ? IDLE : r_state;

  // done is gated by reset so an access abandoned by reset never reports completion
  always_comb begin
    cpu_done_o = (r_state == CPU_BUSY) & mem_ready_i & ~rst_i;
    vga_done_o = (r_state == VGA_BUSY) & mem_ready_i & ~rst_i;
    cpu_data_o = cpu_done_o ? mem_data_i : '0;
    vga_data_o = vga_done_o ? mem_data_i : '0;
    cpu_stall_o = w_cpu_req & ~cpu_done_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mem_r <= 1'b0;
      r_mem_w <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_run <= '0;
      r_wait <= '0;
    end else begin
      if (w_vga_grant) begin
        r_mem_r <= 1'b1;
        r_mem_w <= 1'b0;
        r_mem_addr <= vga_addr_i;
        r_mem_data <= '0;
      end else if (w_cpu_grant) begin
        r_mem_r <= cpu_r_v_i;
        r_mem_w <= cpu_w_v_i & ~cpu_r_v_i;
        r_mem_addr <= cpu_addr_i;
        r_mem_data <= cpu_data_i;
      end else if (w_fin) begin
        r_mem_r <= 1'b0;
        r_mem_w <= 1'b0;
      end
      if (w_vga_grant | (w_idle & ~vga_r_v_i)) r_run <= '0;
      else if (w_cpu_grant & vga_r_v_i & (r_run < run_max)) r_run <= r_run + 1'b1;
      if (w_vga_grant) r_wait <= '0;
      else if (w_vga_waiting & (r_wait < wait_max)) r_wait <= r_wait + 1'b1;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] r_perf_stall, r_perf_wait;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_stall <= '0;
      r_perf_wait <= '0;
    end else begin
      r_perf_stall <= r_perf_stall + {31'd0, cpu_stall_o};
      r_perf_wait <= r_perf_wait + {31'd0, w_vga_waiting};
    end
  end
  assign perf_cpu_stall_o = r_perf_stall;
  assign perf_vga_wait_o = r_perf_wait;
`endif

  a_rw_excl: assert property (@(posedge clk_i) disable iff (rst_i) !(cpu_r_v_i && cpu_w_v_i));
endmodule
